// File: rtl/cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfg_pkg
// Description : Shared types and defaults for the PE configuration-chain
//               loader: FSM state encoding, default widths, word-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cfg_pkg;

  localparam int C_WORD_W     = 32;
  localparam int C_LEN_W      = 16;
  localparam int C_CLR_CYCLES = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_LOAD   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  // Number of configuration words a load of `len` bits consumes.
  function automatic int unsigned ceil_words(input int unsigned len,
                                             input int unsigned word_w = C_WORD_W);
    return (len + word_w - 1) / word_w;
  endfunction

endpackage : cfg_pkg
`default_nettype wire

// File: rtl/cfg_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : cfg_word_serializer
// Description : One-entry word buffer that streams configuration words onto
//               the chain LSB-first. A word arriving into an empty buffer
//               emits its bit 0 in the same cycle, and the next word may be
//               taken while the last bit of the current one is emitted, so
//               an always-valid source sees no bubble at word boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_word_serializer
  import cfg_pkg::*;
#(
  parameter int WORD_W = C_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load_en,     // loader is in its shifting phase
  input  logic              i_flush,       // drop buffered word, rewind index
  input  logic              i_stop,        // no bits left to shift
  input  logic              i_last_bit,    // exactly one bit left to shift
  input  logic [WORD_W-1:0] i_word_data,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  output logic              o_step,        // a bit is emitted on this edge
  output logic              o_cfg_bit,
  output logic              o_cfg_shift
);

  localparam int              IDX_W      = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] r_buf;
  logic              r_full;
  logic [IDX_W-1:0]  r_idx;
  logic              r_cfg_bit;
  logic              r_cfg_shift;

  logic              w_active;
  logic              w_at_last;
  logic              w_ready;
  logic              w_accept;
  logic              w_step;
  logic [WORD_W-1:0] w_cur;

  // The final chain bit never opens the buffer for another word, so a load
  // consumes only the words it needs.
  always_comb begin
    w_active  = i_load_en & ~i_flush & ~i_stop;
    w_at_last = (r_idx == C_LAST_IDX);
    w_ready   = w_active & (~r_full | (w_at_last & ~i_last_bit));
    w_accept  = w_ready & i_word_valid;
    w_step    = w_active & (r_full | w_accept);
    w_cur     = r_full ? r_buf : i_word_data;
  end

  // Buffer occupancy, bit index and the registered chain drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf       <= '0;
      r_full      <= 1'b0;
      r_idx       <= '0;
      r_cfg_bit   <= 1'b0;
      r_cfg_shift <= 1'b0;
    end else begin
      r_cfg_shift <= w_step;
      if (w_step) begin
        r_cfg_bit <= w_cur[r_idx];
      end
      if (i_flush) begin
        r_full <= 1'b0;
        r_idx  <= '0;
      end else if (w_step) begin
        if (w_at_last) begin
          r_idx  <= '0;
          r_full <= w_accept;
        end else begin
          r_idx  <= r_idx + 1'b1;
          r_full <= 1'b1;
        end
        if (w_accept) begin
          r_buf <= i_word_data;
        end
      end
    end
  end

  assign o_word_ready = w_ready;
  assign o_step       = w_step;
  assign o_cfg_bit    = r_cfg_bit;
  assign o_cfg_shift  = r_cfg_shift;

endmodule : cfg_word_serializer
`default_nettype wire

// File: rtl/cfg_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : cfg_chain_loader
// Description : Sequences one PE configuration chain: clears the chain for a
//               fixed number of cycles, then shifts chain_len bits taken from
//               a valid/ready word stream, with abort and done signalling.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_chain_loader
  import cfg_pkg::*;
#(
  parameter int WORD_W     = C_WORD_W,
  parameter int LEN_W      = C_LEN_W,
  parameter int CLR_CYCLES = C_CLR_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [LEN_W-1:0]  i_chain_len,
  input  logic [WORD_W-1:0] i_word_data,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  output logic              o_cfg_bit,
  output logic              o_cfg_shift,
  output logic              o_cfg_reset,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_aborted
);

  localparam int               CLR_W      = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] C_CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  state_t             r_state;
  state_t             w_next;
  logic [LEN_W-1:0]   r_bits_left;
  logic [CLR_W-1:0]   r_clr_cnt;
  logic               r_cfg_reset;
  logic               r_busy;
  logic               r_done;
  logic               r_aborted;

  logic               w_abort_ok;
  logic               w_step;
  logic               w_in_load;

  assign w_in_load = (r_state == S_LOAD);

  cfg_word_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .clk          (clk),
    .reset        (reset),
    .i_load_en    (w_in_load & ~i_abort),
    .i_flush      (~w_in_load | i_abort),
    .i_stop       (r_bits_left == '0),
    .i_last_bit   (r_bits_left == LEN_W'(1)),
    .i_word_data  (i_word_data),
    .i_word_valid (i_word_valid),
    .o_word_ready (o_word_ready),
    .o_step       (w_step),
    .o_cfg_bit    (o_cfg_bit),
    .o_cfg_shift  (o_cfg_shift)
  );

  // Next-state decode; abort only applies while a load is in flight.
  always_comb begin
    w_next     = r_state;
    w_abort_ok = i_abort & ((r_state == S_CLEAR) | (r_state == S_LOAD));
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        if (w_abort_ok)                   w_next = S_IDLE;
        else if (r_clr_cnt == C_CLR_LAST) w_next = (r_bits_left == '0) ? S_FINISH : S_LOAD;
      end
      S_LOAD: begin
        if (w_abort_ok)                                w_next = S_IDLE;
        else if (w_step && r_bits_left == LEN_W'(1))   w_next = S_FINISH;
      end
      S_FINISH: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register and the registered status/clear outputs derived from it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cfg_reset <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cfg_reset <= (w_next == S_CLEAR);
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (r_state == S_FINISH);
      r_aborted   <= w_abort_ok;
    end
  end

  // Remaining-bit counter and clear-phase cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bits_left <= '0;
      r_clr_cnt   <= '0;
    end else if (r_state == S_IDLE && i_start) begin
      r_bits_left <= i_chain_len;
      r_clr_cnt   <= '0;
    end else begin
      if (r_state == S_CLEAR && r_clr_cnt != C_CLR_LAST) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
      if (w_step) begin
        r_bits_left <= r_bits_left - 1'b1;
      end
    end
  end

  assign o_cfg_reset = r_cfg_reset;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_aborted   = r_aborted;

endmodule : cfg_chain_loader
`default_nettype wire

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
- Sequences the serial configuration chain of a PE block: ALU/MEM config cells plus the 2x1 and 4x4 fully-connected switch cells, daisy-chained through config_in/config_out.
- Accepts configuration words over a valid/ready stream and serialises them LSB-first onto the chain.
- Produces a per-cycle shift enable that gates the chain's config clock, and a chain-clear pulse that drives config_reset.
- Sits between the array-level bitstream fetch logic and one PE (or one row of PEs) chain.

Parameters:
- WORD_W, 32, width of incoming configuration words.
- LEN_W, 16, width of the runtime chain-length input, in bits.
- CLR_CYCLES, 2, number of cycles cfg_reset is held high at the start of a load.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- abort  input  1  terminates an in-progress load.
- chain_len  input  LEN_W  number of bits to shift; sampled when start is accepted.
- word_data  input  WORD_W  configuration word, bit 0 shifted first.
- word_valid  input  1  word_data is valid.
- word_ready  output  1  loader accepts word_data this cycle.
- cfg_bit  output  1  drives chain config_in.
- cfg_shift  output  1  high = chain shifts cfg_bit on this clk edge; drives the config-clock gate.
- cfg_reset  output  1  drives chain config_reset.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a load completes normally.
- aborted  output  1  one-cycle pulse when a load ends via abort.

Behaviour:
- Reset (async assert):
  - State goes to IDLE.
  - word_ready, cfg_bit, cfg_shift, cfg_reset, busy, done and aborted all go to 0.
  - Word buffer is emptied and all counters are zeroed.
  - Chain contents are undefined after a reset mid-load; the next start re-clears the chain.
- All outputs are registered except word_ready, which is combinational from state and buffer occupancy.
- FSM states: IDLE, CLEAR, LOAD, FINISH.
- IDLE:
  - On start=1, latch chain_len into bits_left and go to CLEAR.
  - start while busy is ignored.
- CLEAR:
  - cfg_reset=1 for exactly CLR_CYCLES cycles, then go to LOAD.
  - If the latched chain_len is 0, go directly to FINISH instead.
  - cfg_shift=0 throughout.
- LOAD:
  - One-entry word buffer plus a bit index of width clog2(WORD_W).
  - word_ready=1 when the buffer is empty, or when it is presenting its last bit this cycle (back-to-back words, no bubble).
  - Handshake: a word transfers only when word_valid & word_ready.
  - Each cycle the buffer holds a word: cfg_bit = buffer[bit_idx], cfg_shift=1, bit_idx increments, bits_left decrements.
  - When bit_idx wraps (WORD_W-1 -> 0), the buffer is emptied unless a new word is accepted that cycle.
  - Buffer empty (stall): cfg_shift=0, cfg_bit holds its last value, counters hold.
  - When bits_left reaches 0 after a shift, go to FINISH. Remaining upper bits of a partially used final word are discarded.
  - word_ready=0 once bits_left=0, so no word beyond ceil(chain_len/WORD_W) is consumed.
- FINISH:
  - done=1 for one cycle, cfg_shift=0, then go to IDLE.
- abort in CLEAR or LOAD:
  - Next state is IDLE, with aborted=1 for one cycle.
  - cfg_shift and cfg_reset drop to 0 in that cycle; the buffer is emptied.
  - No word is accepted in the abort cycle (word_ready=0 while abort=1).
  - abort in IDLE or FINISH is ignored.
- abort and start in the same cycle while busy: abort wins and start is ignored.
- Shift count invariant: between start acceptance and done, exactly chain_len cycles have cfg_shift=1.
- Latency:
  - First shift is at earliest CLR_CYCLES+1 cycles after start.
  - done occurs 1 cycle after the final shift.

Decomposition:
- Shared package cfg_pkg:
  - FSM state enum (IDLE, CLEAR, LOAD, FINISH).
  - Default WORD_W, LEN_W, CLR_CYCLES constants.
  - A function ceil_words(len) giving the number of words a load consumes.
- One natural sub-module, cfg_word_serializer: the one-entry buffer, bit index, word_ready generation and cfg_bit/cfg_shift generation. Its interface is load-enable, flush and a bits_left==0 stop input.
- The top level holds the FSM, bits_left counter and the clear-pulse counter.

Test Plan:
- chain_len=5, word 0x00000015 valid at start: cfg_reset high 2 cycles, then cfg_bit = 1,0,1,0,1 on 5 consecutive cfg_shift cycles; done 1 cycle later; exactly 1 word accepted.
- chain_len=40, word 0xFFFFFFFF then 0x000000A5 presented with a 3-cycle valid gap: 32 shifts, 3 stall cycles (cfg_shift=0), then 8 shifts of 1,0,1,0,0,1,0,1; total 40 shifts; exactly 2 words accepted; a third offered word is not accepted.
- chain_len=64, words always valid: 64 consecutive cfg_shift cycles with no bubble at the word boundary; word_ready is high in the last-bit cycle of word 0.
- chain_len=0: CLEAR for 2 cycles, done, no word accepted, zero shifts.
- Abort 10 cycles into a chain_len=100 load: aborted pulse, busy=0 next cycle, cfg_shift=0; a following start runs a full clean load with cfg_reset re-asserted.
- Async reset asserted mid-LOAD (between clock edges): all outputs 0 immediately; start asserted while busy in a separate run is ignored and the shift count is unchanged.
